bcd_updown_counter_n: RTL and testbench

//  Parametrised N-digit packed-BCD up/down counter with synchronous load, enable and

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_cell.sv | 27 ++
 rtl/bcd_updown_counter_n.sv | 112 +++++++++++
 tb/tb_bcd_updown_counter_n.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the N-digit up/down counter.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction

    // Whole-value a <= b over the low n digits; higher digits override lower ones.
    function automatic logic bcd_le(input logic [31:0] a, input logic [31:0] b, input int n);
        logic le;
        le = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                if (a[4*i +: 4] < b[4*i +: 4]) begin
                    le = 1'b1;
                end else if (a[4*i +: 4] > b[4*i +: 4]) begin
                    le = 1'b0;
                end
            end
        end
        return le;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter: next value for a single step plus boundary flags.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       step,
    input  logic       up_dn,
    input  bcd_digit_t digit,
    output bcd_digit_t next_digit,
    output logic       at_max,
    output logic       at_min
);

    assign at_max = (digit == BCD_MAX);
    assign at_min = (digit == 4'd0);

    always_comb begin
        next_digit = digit;
        if (step) begin
            if (up_dn) begin
                next_digit = at_max ? 4'd0 : digit + 4'd1;
            end else begin
                next_digit = at_min ? BCD_MAX : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit packed-BCD up/down counter with load validation and a 0..LIMIT range.
// Build option: define BCD_SATURATE_EN to hold at the bounds instead of wrapping.
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int                    DIGITS    = 2,
    parameter logic [4*DIGITS-1:0]   LIMIT     = {DIGITS{4'h9}},
    parameter logic [4*DIGITS-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  zero,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    count_q, count_d;
    logic            load_err_q, load_err_d;
    logic [W-1:0]    stepped;
    logic [DIGITS:0] step_c;
    logic [DIGITS-1:0] at_max, at_min;
    logic            at_limit, at_zero, wrap_up, wrap_dn;
    logic            load_valid, count_ok;
    logic [31:0]     load_val_32, limit_32, count_32;

    // Each digit steps only when every lower digit is about to roll over.
    assign step_c[0] = en;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .step       (step_c[i]),
            .up_dn      (up_dn),
            .digit      (count_q[4*i +: 4]),
            .next_digit (stepped[4*i +: 4]),
            .at_max     (at_max[i]),
            .at_min     (at_min[i])
        );
        assign step_c[i+1] = step_c[i] & (up_dn ? at_max[i] : at_min[i]);
    end

    assign at_limit = (count_q == LIMIT);
    assign at_zero  = &at_min;
    // A ripple out of the top digit can only happen at LIMIT, so it folds into the same wrap.
    assign wrap_up  = up_dn & (at_limit | step_c[DIGITS]);
    assign wrap_dn  = ~up_dn & at_zero;

    always_comb begin
        load_val_32 = '0;
        limit_32    = '0;
        count_32    = '0;
        load_val_32[W-1:0] = load_val;
        limit_32[W-1:0]    = LIMIT;
        count_32[W-1:0]    = count_q;
        load_valid = bcd_le(load_val_32, limit_32, DIGITS);
        count_ok   = bcd_le(count_32, limit_32, DIGITS);
        for (int i = 0; i < DIGITS; i++) begin
            load_valid = load_valid & is_bcd(load_val[4*i +: 4]);
            count_ok   = count_ok & is_bcd(count_q[4*i +: 4]);
        end
    end

    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (load) begin
            load_err_d = ~load_valid;
            if (load_valid) begin
                count_d = load_val;
            end
        end else if (en) begin
`ifdef BCD_SATURATE_EN
            if (wrap_up || wrap_dn) begin
                count_d = count_q;
            end else begin
                count_d = stepped;
            end
`else
            if (wrap_up) begin
                count_d = '0;
            end else if (wrap_dn) begin
                count_d = LIMIT;
            end else begin
                count_d = stepped;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= RESET_VAL;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign load_err = load_err_q;
    assign zero     = at_zero;
    assign tc       = en & ~load & (up_dn ? at_limit : at_zero);

    a_count_in_range: assert property (@(posedge clk) disable iff (reset) count_ok);

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench for bcd_updown_counter_n with DIGITS=2, LIMIT=8'h59, RESET_VAL=8'h00.
module tb_bcd_updown_counter_n;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       zero;
    logic       load_err;

    int checks;
    int errors;

    bcd_updown_counter_n #(
        .DIGITS    (2),
        .LIMIT     (8'h59),
        .RESET_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .zero     (zero),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'h33;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (count !== 8'h00) begin errors++; $display("FAIL reset_count got %h exp 00", count); end
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b exp 0", load_err); end
        checks++;
        if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
        reset = 1'b0; en = 1'b0; load = 1'b0;
        @(negedge clk);
        checks++;
        if (tc !== 1'b0 || count !== 8'h00) begin
            errors++; $display("FAIL idle_hold got count %h tc %b exp 00 0", count, tc);
        end
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_v [4];
        exp_v = '{8'h58, 8'h59, 8'h00, 8'h01};
        do_load(8'h58);
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (count !== exp_v[i]) begin errors++; $display("FAIL up_count[%0d] got %h exp %h", i, count, exp_v[i]); end
            checks++;
            if (tc !== (exp_v[i] == 8'h59)) begin errors++; $display("FAIL up_tc[%0d] got %b exp %b", i, tc, exp_v[i] == 8'h59); end
            if (i < 3) @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [7:0] exp_v [12];
        exp_v = '{8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h59};
        do_load(8'h10);
        en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (count !== exp_v[i]) begin errors++; $display("FAIL down_count[%0d] got %h exp %h", i, count, exp_v[i]); end
            checks++;
            if (tc !== (exp_v[i] == 8'h00)) begin errors++; $display("FAIL down_tc[%0d] got %b exp %b", i, tc, exp_v[i] == 8'h00); end
            checks++;
            if (zero !== (exp_v[i] == 8'h00)) begin errors++; $display("FAIL down_zero[%0d] got %b exp %b", i, zero, exp_v[i] == 8'h00); end
            if (i < 11) @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic test_invalid_load();
        logic [7:0] bad [2];
        bad = '{8'h5A, 8'h60};
        for (int i = 0; i < 2; i++) begin
            do_load(bad[i]);
            checks++;
            if (count !== 8'h59) begin errors++; $display("FAIL bad_load_count[%0d] got %h exp 59", i, count); end
            checks++;
            if (load_err !== 1'b1) begin errors++; $display("FAIL bad_load_err[%0d] got %b exp 1", i, load_err); end
            @(negedge clk);
            checks++;
            if (load_err !== 1'b0 || count !== 8'h59) begin
                errors++; $display("FAIL bad_load_after[%0d] got err %b count %h exp 0 59", i, load_err, count);
            end
        end
        do_load(8'h59);
        checks++;
        if (count !== 8'h59 || load_err !== 1'b0) begin
            errors++; $display("FAIL limit_load got count %h err %b exp 59 0", count, load_err);
        end
    endtask

    task automatic test_load_priority();
        en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'h33;
        #1;
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL load_tc got %b exp 0", tc); end
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        checks++;
        if (count !== 8'h33) begin errors++; $display("FAIL load_wins got %h exp 33", count); end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; up_dn = 1'b1;
        @(negedge clk);
        up_dn = 1'b0;
        checks++;
        if (count !== 8'h34) begin errors++; $display("FAIL rev_up got %h exp 34", count); end
        @(negedge clk);
        checks++;
        if (count !== 8'h33) begin errors++; $display("FAIL rev_down got %h exp 33", count); end
        up_dn = 1'b1;
        do_load(8'h39);
        @(negedge clk);
        checks++;
        if (count !== 8'h40) begin errors++; $display("FAIL carry got %h exp 40", count); end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        en = 1'b1; up_dn = 1'b1; reset = 1'b1; load = 1'b1; load_val = 8'h12;
        @(negedge clk);
        reset = 1'b0; load = 1'b0; en = 1'b0;
        checks++;
        if (count !== 8'h00 || load_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid got count %h err %b exp 00 0", count, load_err);
        end
    endtask

    task automatic test_bounds_mode();
`ifdef BCD_SATURATE_EN
        do_load(8'h59);
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (tc !== 1'b1) begin errors++; $display("FAIL sat_up_tc[%0d] got %b exp 1", i, tc); end
            @(negedge clk);
            checks++;
            if (count !== 8'h59) begin errors++; $display("FAIL sat_up[%0d] got %h exp 59", i, count); end
        end
        en = 1'b0;
        do_load(8'h00);
        en = 1'b1; up_dn = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin errors++; $display("FAIL sat_dn_tc got %b exp 1", tc); end
        @(negedge clk);
        checks++;
        if (count !== 8'h00) begin errors++; $display("FAIL sat_dn got %h exp 00", count); end
        en = 1'b0;
`else
        do_load(8'h59);
        en = 1'b1; up_dn = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 8'h00) begin errors++; $display("FAIL wrap_up got %h exp 00", count); end
        up_dn = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 8'h59) begin errors++; $display("FAIL wrap_dn got %h exp 59", count); end
        en = 1'b0;
`endif
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_invalid_load();
        test_load_priority();
        test_back_to_back();
        test_reset_mid();
        test_bounds_mode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
